// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and default timing for the async-SRAM controller
package sram_pkg;
    typedef enum logic [2:0] {IDLE, RD, WSETUP, WR, WHOLD, RECOVER} state_t;
    localparam int RD_CYC_DEF   = 4;
    localparam int WR_CYC_DEF   = 4;
    localparam int TURN_CYC_DEF = 1;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter that flags the last cycle of a phase
module sram_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign done = cnt == '0;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end sequencing an asynchronous SRAM with
// parameterised read, write and bus-turnaround phase lengths
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int AW       = 17,
    parameter int DW       = 8,
    parameter int RD_CYC   = RD_CYC_DEF,
    parameter int WR_CYC   = WR_CYC_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dq_in,
    output logic [DW-1:0] ram_dq_out,
    output logic          ram_dq_oe,
    output logic          ram_ce_,
    output logic          ram_oe_,
    output logic          ram_we_
);
    localparam int CW = $clog2(max3(RD_CYC, WR_CYC, TURN_CYC)) + 1;

    state_t        state, next_state;
    logic          done, load;
    logic [CW-1:0] load_val;
    logic          ce_d, oe_d, we_d, dq_oe_d;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = state != IDLE;
    assign load      = next_state != state;
    assign load_val  = next_state == RD      ? CW'(RD_CYC - 1) :
                       next_state == WR      ? CW'(WR_CYC - 1) :
                       next_state == RECOVER ? CW'(TURN_CYC - 1) : '0;

    sram_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ram_ce_    <= 1'b1;
            ram_oe_    <= 1'b1;
            ram_we_    <= 1'b1;
            ram_dq_oe  <= 1'b0;
            ram_addr   <= '0;
            ram_dq_out <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state     <= next_state;
            ram_ce_   <= ce_d;
            ram_oe_   <= oe_d;
            ram_we_   <= we_d;
            ram_dq_oe <= dq_oe_d;
            rsp_valid <= (state == RD) && done;
            if ((state == RD) && done)
                rsp_rdata <= ram_dq_in;
            if (req_valid && req_ready) begin
                ram_addr   <= req_addr;
                ram_dq_out <= req_wdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_write ? WSETUP : RD;
            RD:      if (done) next_state = RECOVER;
            WSETUP:  next_state = WR;
            WR:      if (done) next_state = WHOLD;
            WHOLD:   next_state = RECOVER;
            RECOVER: if (done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from the upcoming state so they align with it
    always_comb begin
        ce_d    = !(next_state inside {RD, WSETUP, WR, WHOLD});
        oe_d    = next_state != RD;
        we_d    = next_state != WR;
        dq_oe_d = next_state inside {WSETUP, WR, WHOLD};
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl at default timing and a swept
// parameter set, each instance driving a behavioural SRAM
module tb_sram_ctrl;
    localparam int RD2 = 1, WR2 = 7, TURN2 = 3;

    logic clk = 0;
    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    bit mon_en = 0;

    logic        rst1 = 1, v1 = 0, w1 = 0, rdy1, rspv1, busy1, ce1, oe1, we1, dqoe1;
    logic [16:0] a1 = '0, addr1;
    logic [7:0]  d1 = '0, rdata1, dqi1, dqo1;
    logic        rst2 = 1, v2 = 0, w2 = 0, rdy2, rspv2, busy2, ce2, oe2, we2, dqoe2;
    logic [18:0] a2 = '0, addr2;
    logic [15:0] d2 = '0, rdata2, dqi2, dqo2;

    sram_ctrl dut1 (
        .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1), .rsp_valid(rspv1), .rsp_rdata(rdata1),
        .busy(busy1), .ram_addr(addr1), .ram_dq_in(dqi1), .ram_dq_out(dqo1),
        .ram_dq_oe(dqoe1), .ram_ce_(ce1), .ram_oe_(oe1), .ram_we_(we1)
    );

    sram_ctrl #(.AW(19), .DW(16), .RD_CYC(RD2), .WR_CYC(WR2), .TURN_CYC(TURN2)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(v2), .req_ready(rdy2), .req_write(w2),
        .req_addr(a2), .req_wdata(d2), .rsp_valid(rspv2), .rsp_rdata(rdata2),
        .busy(busy2), .ram_addr(addr2), .ram_dq_in(dqi2), .ram_dq_out(dqo2),
        .ram_dq_oe(dqoe2), .ram_ce_(ce2), .ram_oe_(oe2), .ram_we_(we2)
    );

    logic [7:0]  mem1 [256];
    logic [15:0] mem2 [256];
    always @(posedge clk) begin
        if (!ce1 && !we1) mem1[addr1[7:0]] <= dqo1;
        if (!ce2 && !we2) mem2[addr2[7:0]] <= dqo2;
    end
    assign dqi1 = (!ce1 && !oe1) ? mem1[addr1[7:0]] : 8'h00;
    assign dqi2 = (!ce2 && !oe2) ? mem2[addr2[7:0]] : 16'h0000;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
        end
    endtask

    int acc1 = 0, rsp_cnt1 = 0;
    always @(posedge clk) if (mon_en && v1 && rdy1) acc1++;

    int gap1 = 100, we1_run = 0, we1_w = 0, oe1_run = 0, oe1_w = 0, dqoe1_run = 0, dqoe1_w = 0;
    logic oe1_q = 1;
    always @(negedge clk) if (mon_en) begin
        chk("excl1", {29'd0, !we1 && !oe1, dqoe1 && !oe1, !we1 && !dqoe1}, 0);
        if (oe1_q && !oe1) chk("gap1", 32'(gap1 >= 1), 1);
        gap1  = dqoe1 ? 0 : gap1 + 1;
        oe1_q = oe1;
        if (rspv1) rsp_cnt1++;
        if (!we1) we1_run++; else if (we1_run != 0) begin we1_w = we1_run; we1_run = 0; end
        if (!oe1) oe1_run++; else if (oe1_run != 0) begin oe1_w = oe1_run; oe1_run = 0; end
        if (dqoe1) dqoe1_run++; else if (dqoe1_run != 0) begin dqoe1_w = dqoe1_run; dqoe1_run = 0; end
    end

    int gap2 = 100, we2_run = 0, we2_w = 0, oe2_run = 0, oe2_w = 0, dqoe2_run = 0, dqoe2_w = 0;
    logic oe2_q = 1;
    always @(negedge clk) if (mon_en) begin
        chk("excl2", {29'd0, !we2 && !oe2, dqoe2 && !oe2, !we2 && !dqoe2}, 0);
        if (oe2_q && !oe2) chk("gap2", 32'(gap2 >= TURN2), 1);
        gap2  = dqoe2 ? 0 : gap2 + 1;
        oe2_q = oe2;
        if (!we2) we2_run++; else if (we2_run != 0) begin we2_w = we2_run; we2_run = 0; end
        if (!oe2) oe2_run++; else if (oe2_run != 0) begin oe2_w = oe2_run; oe2_run = 0; end
        if (dqoe2) dqoe2_run++; else if (dqoe2_run != 0) begin dqoe2_w = dqoe2_run; dqoe2_run = 0; end
    end

    // Issue one access at a negedge; lat counts from the accept edge (1) to
    // rsp_valid visible (reads) or req_ready visible again (writes)
    task automatic access(input bit s, input bit w, input logic [18:0] a, input logic [15:0] d,
                          output logic [15:0] q, output int lat);
        int k;
        if (s) begin v2 = 1; w2 = w; a2 = a; d2 = d; end
        else begin v1 = 1; w1 = w; a1 = a[16:0]; d1 = d[7:0]; end
        k = 0;
        while (!(s ? rdy2 : rdy1) && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        v1 = 0; v2 = 0;
        lat = 1;
        while (!(w ? (s ? rdy2 : rdy1) : (s ? rspv2 : rspv1)) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (k >= 50 || lat >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: access s=%0d w=%0d addr=0x%0h did not complete", s, w, a);
        end
        q = s ? rdata2 : {8'h00, rdata1};
    endtask

    typedef struct packed {
        logic        rst, v, w;
        logic [16:0] a;
        logic [7:0]  d;
        logic [6:0]  st;
        logic [7:0]  rd;
    } vec_t;
    vec_t vt [17];

    initial begin
        logic [15:0] q;
        int lat, r0, c0, t1, t2, p;
        // st = {ce_, oe_, we_, dq_oe, req_ready, busy, rsp_valid}
        vt[0]  = '{1'b1, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_000, 8'h00};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 17'h5,  8'h0,  7'b1110_000, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_100, 8'h00};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 17'hff, 8'ha5, 7'b0111_010, 8'h00};
        for (int i = 4; i <= 7; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 17'h0, 8'h0, 7'b0101_010, 8'h00};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b0111_010, 8'h00};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_010, 8'h00};
        vt[10] = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_100, 8'h00};
        vt[11] = '{1'b0, 1'b1, 1'b0, 17'hff, 8'h0,  7'b0010_010, 8'h00};
        for (int i = 12; i <= 14; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 17'h0, 8'h0, 7'b0010_010, 8'h00};
        vt[15] = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_011, 8'ha5};
        vt[16] = '{1'b0, 1'b0, 1'b0, 17'h0,  8'h0,  7'b1110_100, 8'ha5};

        for (int i = 0; i < 17; i++) begin
            rst1 = vt[i].rst; v1 = vt[i].v; w1 = vt[i].w; a1 = vt[i].a; d1 = vt[i].d;
            @(negedge clk);
            mon_en = 1;
            chk($sformatf("vec%0d", i), {17'd0, ce1, oe1, we1, dqoe1, rdy1, busy1, rspv1, rdata1},
                {17'd0, vt[i].st, vt[i].rd});
        end
        rst2 = 0;
        chk("addr_latched", {15'd0, addr1}, 32'hff);

        access(0, 0, 19'hff, 16'h0, q, lat);
        chk("rd_lat", lat, 5);
        chk("rd_data", q, 16'h00a5);
        we1_w = 0; dqoe1_w = 0;
        access(0, 1, 19'h10, 16'h3c, q, lat);
        chk("wr_lat", lat, 8);
        chk("we_width", we1_w, 4);
        chk("dqoe_width", dqoe1_w, 6);

        // Reset during the second RD cycle
        v1 = 1; w1 = 0; a1 = 17'h10;
        @(negedge clk);
        v1 = 0;
        @(negedge clk);
        chk("rd2_oe_low", {31'd0, oe1}, 0);
        r0 = rsp_cnt1;
        rst1 = 1;
        @(negedge clk);
        chk("rst_strobes", {26'd0, ce1, oe1, we1, dqoe1, busy1, rdy1}, 6'b111000);
        chk("rst_rdata", {24'd0, rdata1}, 0);
        rst1 = 0;
        repeat (8) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt1 - r0, 0);
        access(0, 0, 19'h10, 16'h0, q, lat);
        chk("post_rst_rd", q, 16'h003c);

        // Request held valid across busy: accepted once per RD+RECOVER round
        access(0, 1, 19'h20, 16'h77, q, lat);
        r0 = rsp_cnt1; c0 = acc1; t1 = 0; t2 = 0;
        v1 = 1; w1 = 0; a1 = 17'h20;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (acc1 - c0 == 1 && t1 == 0) t1 = i;
            if (acc1 - c0 == 2) begin t2 = i; break; end
        end
        v1 = 0;
        chk("reissue_gap", t2 - t1, 6);
        repeat (10) @(negedge clk);
        chk("reissue_accepts", acc1 - c0, 2);
        chk("reissue_rsps", rsp_cnt1 - r0, 2);
        chk("reissue_data", {24'd0, rdata1}, 32'h77);

        // Linked-list fill and pointer chase
        for (int a = 0; a < 256; a++) access(0, 1, 19'(a), 16'((a + 1) & 8'hff), q, lat);
        p = 0;
        for (int h = 0; h < 1000; h++) begin
            access(0, 0, 19'(p), 16'h0, q, lat);
            p = int'(q[7:0]);
        end
        chk("chase_final", p, 232);

        // Swept parameter instance
        we2_w = 0; dqoe2_w = 0; oe2_w = 0;
        access(1, 1, 19'h40012, 16'hbeef, q, lat);
        chk("p_wr_lat", lat, WR2 + TURN2 + 3);
        chk("p_we_width", we2_w, WR2);
        chk("p_dqoe_width", dqoe2_w, WR2 + 2);
        chk("p_addr", {13'd0, addr2}, 32'h40012);
        access(1, 0, 19'h40012, 16'h0, q, lat);
        chk("p_rd_lat", lat, RD2 + 1);
        chk("p_rd_data", q, 16'hbeef);
        repeat (2) @(negedge clk);
        chk("p_oe_width", oe2_w, RD2);
        access(1, 1, 19'h40034, 16'h1234, q, lat);
        access(1, 0, 19'h40034, 16'h0, q, lat);
        chk("p_rd_data2", q, 16'h1234);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
